// File: rtl/async_button_pulse.sv
// async_button_pulse: one fixed-length pulse per press of an active-low button.
// out asserts combinationally while in is low and the sample PULSE_CYCLES edges old was high.
module async_button_pulse #(
  parameter int PULSE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);
  logic [PULSE_CYCLES-1:0] hist;
  always_ff @(posedge clk or posedge rst)
    if (rst) hist <= '1;
    else hist <= (hist << 1) | PULSE_CYCLES'(in);
  assign out = ~rst & ~in & hist[PULSE_CYCLES-1];
endmodule

// File: tb/tb_async_button_pulse.sv
// tb_async_button_pulse: scoreboard bench for PULSE_CYCLES = 2, 1 and 4 sharing one stimulus.
module tb_async_button_pulse;
  typedef struct {
    string name;
    logic  e2;
    logic  e1;
    logic  e4;
  } exp_t;

  logic clk = 0;
  logic rst = 1;
  logic in = 1;
  logic out2, out1, out4;
  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  logic samp[$];
  event chk;

  async_button_pulse #(.PULSE_CYCLES(2)) dut2 (.clk(clk), .rst(rst), .in(in), .out(out2));
  async_button_pulse #(.PULSE_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .in(in), .out(out1));
  async_button_pulse #(.PULSE_CYCLES(4)) dut4 (.clk(clk), .rst(rst), .in(in), .out(out4));

  always #5 clk = ~clk;

  // Reference: out = button pressed now and the sample taken p edges ago was "released".
  function automatic logic model(int p);
    return !rst && !in && samp[samp.size() - p];
  endfunction

  task automatic fill_idle();
    samp.delete();
    for (int i = 0; i < 16; i++) samp.push_back(1'b1);
  endtask

  task automatic check(string name);
    exp_t e;
    e.name = name;
    e.e2 = model(2);
    e.e1 = model(1);
    e.e4 = model(4);
    sb.push_back(e);
    ->chk;
    #0;
  endtask

  task automatic edge_update();
    @(posedge clk);
    if (rst) fill_idle();
    else begin
      samp.push_back(in);
      void'(samp.pop_front());
    end
  endtask

  task automatic step(logic v, string name);
    @(negedge clk);
    in = v;
    #2 check(name);
    edge_update();
  endtask

  always begin
    exp_t e;
    @(chk);
    e = sb.pop_front();
    checks += 3;
    if (out2 !== e.e2) begin
      errors++;
      $display("FAIL %s p2: out=%b expected=%b at %0t", e.name, out2, e.e2, $time);
    end
    if (out1 !== e.e1) begin
      errors++;
      $display("FAIL %s p1: out=%b expected=%b at %0t", e.name, out1, e.e1, $time);
    end
    if (out4 !== e.e4) begin
      errors++;
      $display("FAIL %s p4: out=%b expected=%b at %0t", e.name, out4, e.e4, $time);
    end
  end

  initial begin
    fill_idle();
    rst = 1;
    in = 1;
    step(1, "reset");
    step(1, "reset");
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 5; i++) step(1, "idle");
    for (int i = 0; i < 20; i++) step(0, "long_press");
    step(1, "release");
    step(0, "short_press");
    step(1, "short_release");
    step(1, "gap");
    step(1, "gap");
    for (int i = 0; i < 4; i++) step(0, "second_press");
    step(1, "release");
    for (int k = 0; k < 8; k++) begin
      int idle = $urandom_range(5, 2);
      int hold = $urandom_range(20, 1);
      for (int i = 0; i < idle; i++) step(1, "rand_idle");
      for (int i = 0; i < hold; i++) step(0, "rand_hold");
    end
    for (int i = 0; i < 5; i++) step(1, "pre_bounce");
    for (int i = 0; i < 12; i++) step(i[0], "bounce");
    for (int i = 0; i < 12; i++) step(1'($urandom_range(1, 0)), "rand_bounce");
    for (int i = 0; i < 5; i++) step(1, "pre_reset");
    @(negedge clk);
    in = 0;
    #1 check("mid_press");
    #1 rst = 1;
    #1 check("mid_reset");
    edge_update();
    @(negedge clk);
    rst = 0;
    #1 check("post_reset");
    edge_update();
    for (int i = 0; i < 6; i++) step(0, "post_reset_hold");
    step(1, "final_release");
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: left=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
